// File: rtl/cpu_types_pkg.sv
// Shared memory-side types: RAM status codes, data word, and arbiter grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_prio.sv
// Next-grant choice for the IDLE state plus the dcache-over-icache starvation counter.
// Grant is combinational; the counter updates on completions and idle cycles.
module arb_prio
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       idle,
  input  logic       dreq,
  input  logic       iREN,
  input  logic       d_done,
  input  logic       i_done,
  output arb_state_t grant
);

  logic [CNT_W-1:0] starve_cnt;
  logic             forced;

  assign forced = iREN && (starve_cnt >= CNT_W'(STARVE_LIM));

  always_comb begin
    grant = IDLE;
    if (dreq && !forced)
      grant = DACC;
    else if (iREN)
      grant = IACC;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= '0;
    else if (i_done || (idle && !iREN))
      starve_cnt <= '0;
    else if (d_done && iREN && (starve_cnt < CNT_W'(STARVE_LIM)))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache and icache onto one RAM port; min 2 cycles request->completion, every completion returns via IDLE.
// Requesters stall on dwait/iwait until ramstate reports ACCESS; ERROR is retried, dropping the request aborts.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state, next_state, grant;
  logic       dreq, d_done, i_done;

  assign dreq   = dREN | dWEN;
  assign d_done = (state == DACC) && dreq && (ramstate == ACCESS);
  assign i_done = (state == IACC) && iREN && (ramstate == ACCESS);

  arb_prio #(
    .STARVE_LIM(STARVE_LIM),
    .CNT_W     (CNT_W)
  ) u_prio (
    .CLK   (CLK),
    .nRST  (nRST),
    .idle  (state == IDLE),
    .dreq  (dreq),
    .iREN  (iREN),
    .d_done(d_done),
    .i_done(i_done),
    .grant (grant)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    dwait      = 1'b1;
    iwait      = 1'b1;
    dload      = '0;
    iload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      IDLE: next_state = grant;
      DACC: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          // A simultaneous read+write request is served as the write.
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            next_state = IDLE;
          end
        end
      end
      IACC: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus starvation, abort and async-reset sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      dREN, dWEN, iREN;
  word_t     daddr, dstore, iaddr, ramload;
  ramstate_t ramstate;
  logic      dwait, iwait, ramREN, ramWEN;
  word_t     dload, iload, ramaddr, ramstore;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_LIM(4), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic      dren, dwen, iren;
    word_t     da, ds, ia;
    ramstate_t rs;
    word_t     rl;
    logic      e_dwait, e_iwait, e_ren, e_wen;
    word_t     e_addr, e_store, e_dload, e_iload;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(logic dren, logic dwen, logic iren, word_t da, word_t ds, word_t ia,
                              ramstate_t rs, word_t rl, logic e_dwait, logic e_iwait, logic e_ren,
                              logic e_wen, word_t e_addr, word_t e_store, word_t e_dload, word_t e_iload);
    vec_t v;
    v.dren = dren; v.dwen = dwen; v.iren = iren; v.da = da; v.ds = ds; v.ia = ia;
    v.rs = rs; v.rl = rl; v.e_dwait = e_dwait; v.e_iwait = e_iwait; v.e_ren = e_ren;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store; v.e_dload = e_dload; v.e_iload = e_iload;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".dwait"}, 32'(dwait), 32'd1);
    chk({tag, ".iwait"}, 32'(iwait), 32'd1);
    chk({tag, ".ramREN"}, 32'(ramREN), 32'd0);
    chk({tag, ".ramWEN"}, 32'(ramWEN), 32'd0);
    chk({tag, ".ramaddr"}, ramaddr, 32'd0);
    chk({tag, ".ramstore"}, ramstore, 32'd0);
    chk({tag, ".dload"}, dload, 32'd0);
    chk({tag, ".iload"}, iload, 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic dr, input logic dw, input logic ir, input word_t da, input word_t ds,
                       input word_t ia, input ramstate_t rs, input word_t rl);
    dREN = dr; dWEN = dw; iREN = ir; daddr = da; dstore = ds; iaddr = ia; ramstate = rs; ramload = rl;
  endtask

  initial begin
    // hold reset with live-looking inputs: outputs must still be at reset values
    nRST = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h77, 32'h88, ACCESS, 32'hFFFF_FFFF);
    #3;
    chk_idle_outputs("reset_pre_edge");
    step();
    chk_idle_outputs("reset_post_edge");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    vt[0]  = mk(1,0,0, 32'h40,0,0, FREE,   32'h0,          1,1,0,0, 32'h0,0,0,0);
    vt[1]  = mk(1,0,0, 32'h40,0,0, ACCESS, 32'hDEADBEEF,   0,1,1,0, 32'h40,0,32'hDEADBEEF,0);
    vt[2]  = mk(0,0,0, 0,0,0,      FREE,   32'h0,          1,1,0,0, 0,0,0,0);
    vt[3]  = mk(1,1,0, 32'h3100,5,0, FREE, 32'h0,          1,1,0,0, 0,0,0,0);
    vt[4]  = mk(1,1,0, 32'h3100,5,0, BUSY, 32'h0,          1,1,0,1, 32'h3100,5,0,0);
    vt[5]  = mk(1,1,0, 32'h3100,5,0, BUSY, 32'h0,          1,1,0,1, 32'h3100,5,0,0);
    vt[6]  = mk(1,1,0, 32'h3100,5,0, BUSY, 32'h0,          1,1,0,1, 32'h3100,5,0,0);
    vt[7]  = mk(1,1,0, 32'h3100,5,0, ACCESS, 32'hAAAA5555, 0,1,0,1, 32'h3100,5,32'hAAAA5555,0);
    vt[8]  = mk(0,0,0, 0,0,0,      FREE,   32'h0,          1,1,0,0, 0,0,0,0);
    vt[9]  = mk(0,0,1, 0,0,32'h8,  FREE,   32'h0,          1,1,0,0, 0,0,0,0);
    vt[10] = mk(0,0,1, 0,0,32'h8,  ERROR,  32'h9999,       1,1,1,0, 32'h8,0,0,0);
    vt[11] = mk(0,0,1, 0,0,32'h8,  ERROR,  32'h9999,       1,1,1,0, 32'h8,0,0,0);
    vt[12] = mk(0,0,1, 0,0,32'h8,  ACCESS, 32'h1234,       1,0,1,0, 32'h8,0,0,32'h1234);
    vt[13] = mk(0,0,0, 0,0,0,      FREE,   32'h0,          1,1,0,0, 0,0,0,0);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].dren, vt[i].dwen, vt[i].iren, vt[i].da, vt[i].ds, vt[i].ia, vt[i].rs, vt[i].rl);
      @(negedge CLK);
      chk($sformatf("vec%0d.dwait", i), 32'(dwait), 32'(vt[i].e_dwait));
      chk($sformatf("vec%0d.iwait", i), 32'(iwait), 32'(vt[i].e_iwait));
      chk($sformatf("vec%0d.ramREN", i), 32'(ramREN), 32'(vt[i].e_ren));
      chk($sformatf("vec%0d.ramWEN", i), 32'(ramWEN), 32'(vt[i].e_wen));
      chk($sformatf("vec%0d.ramaddr", i), ramaddr, vt[i].e_addr);
      chk($sformatf("vec%0d.ramstore", i), ramstore, vt[i].e_store);
      chk($sformatf("vec%0d.dload", i), dload, vt[i].e_dload);
      chk($sformatf("vec%0d.iload", i), iload, vt[i].e_iload);
      step();
    end

    // both caches hammering, RAM always ready: D x4 then a forced I, twice
    for (int c = 1; c <= 20; c++) begin
      logic exp_i, exp_d;
      drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h200, ACCESS, 32'h1000 + 32'(c));
      exp_i = (c == 10) || (c == 20);
      exp_d = ((c % 2) == 0) && !exp_i;
      @(negedge CLK);
      chk($sformatf("starve_c%0d.dwait", c), 32'(dwait), 32'(!exp_d));
      chk($sformatf("starve_c%0d.iwait", c), 32'(iwait), 32'(!exp_i));
      if (exp_i) begin
        chk($sformatf("starve_c%0d.iaddr", c), ramaddr, 32'h200);
        chk($sformatf("starve_c%0d.iload", c), iload, 32'h1000 + 32'(c));
      end
      if (exp_d) begin
        chk($sformatf("starve_c%0d.daddr", c), ramaddr, 32'h100);
        chk($sformatf("starve_c%0d.dload", c), dload, 32'h1000 + 32'(c));
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    step();

    // dcache read abandoned while RAM is busy
    drive(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, FREE, 32'h0);
    step();
    ramstate = BUSY;
    @(negedge CLK);
    chk("abort_busy.ramREN", 32'(ramREN), 32'd1);
    chk("abort_busy.dwait", 32'(dwait), 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, ACCESS, 32'h77);
    @(negedge CLK);
    chk("abort_drop.ramREN", 32'(ramREN), 32'd0);
    chk("abort_drop.dwait", 32'(dwait), 32'd1);
    chk("abort_drop.dload", dload, 32'd0);
    step();
    dREN = 1'b1;
    @(negedge CLK);
    chk("abort_idle.ramREN", 32'(ramREN), 32'd0);
    chk("abort_idle.dwait", 32'(dwait), 32'd1);
    step();
    @(negedge CLK);
    chk("abort_retry.ramREN", 32'(ramREN), 32'd1);
    chk("abort_retry.dwait", 32'(dwait), 32'd0);
    chk("abort_retry.dload", dload, 32'h77);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    step();

    // asynchronous reset in the middle of an icache access
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h44, BUSY, 32'h0);
    step();
    ramstate = ACCESS;
    ramload  = 32'hCAFE;
    @(negedge CLK);
    chk("iacc_pre_reset.iwait", 32'(iwait), 32'd0);
    chk("iacc_pre_reset.ramaddr", ramaddr, 32'h44);
    ramstate = BUSY;
    #1;
    chk("iacc_busy.ramREN", 32'(ramREN), 32'd1);
    ramstate = ACCESS;
    #1;
    nRST = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    step();
    chk_idle_outputs("reset_next_cycle");
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_reset_idle.ramREN", 32'(ramREN), 32'd0);
    step();
    @(negedge CLK);
    chk("post_reset_iacc.iwait", 32'(iwait), 32'd0);
    chk("post_reset_iacc.iload", iload, 32'hCAFE);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache-to-memory request interface. It serves data-cache word requests (dREN/dWEN/daddr/dstore, answered with dwait/dload) and instruction-cache read requests (iREN/iaddr, answered with iwait/iload).
- It arbitrates the two caches onto one single-ported RAM port, whose completion is reported by ramstate.
- It sits between the dcache/icache pair and the RAM model, inside the memory-control layer.

Parameters:
- STARVE_LIM, 4: consecutive dcache grants allowed while iREN is pending before icache is forced a grant (min 1).
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIM.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low for exactly the completing cycle.
- dload  out  32  dcache read data; valid when dwait low and dREN high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low for exactly the completing cycle.
- iload  out  32  icache read data; valid when iwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR (ramstate_t).

Behaviour:
- Reset values: state IDLE, starve counter 0. dwait=1, iwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dload=0, iload=0. An nRST assertion mid-access aborts the access immediately, with no RAM enables in the following cycle.
- States: IDLE, DACC, IACC.
- IDLE:
  - Drives no RAM enables; both waits are high.
  - Grant chosen and registered at the clock edge:
    - dreq (dREN|dWEN) and not forced -> DACC.
    - iREN and (not dreq or forced) -> IACC.
    - Else stay in IDLE.
  - forced = iREN && starve_cnt >= STARVE_LIM.
  - Minimum latency request -> completion is 2 cycles: one IDLE cycle, then one DACC/IACC cycle with ramstate=ACCESS.
- DACC:
  - Drives ramaddr=daddr combinationally.
  - dWEN=1 -> ramWEN=1 and ramstore=dstore. If dREN and dWEN are both high, the write wins; ramREN=0.
  - Otherwise ramREN=1.
  - On ramstate==ACCESS: dwait=0, dload=ramload (same cycle), next state IDLE.
  - On BUSY/FREE/ERROR: dwait=1, stay in DACC. ERROR is retried, never completed.
  - If dREN and dWEN both drop while in DACC: RAM enables go low that cycle, next state IDLE, no completion pulse.
- IACC:
  - Drives ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait=0, iload=ramload, next state IDLE.
  - Other ramstate values and iREN drop follow the same rules as DACC.
- Starve counter:
  - Increments, saturating at STARVE_LIM, on each DACC completion while iREN is high.
  - Clears on each IACC completion, and whenever iREN is low in IDLE.
- Each completion returns through IDLE. Back-to-back dcache words (e.g. a two-word block transfer) therefore cost 2 cycles each minimum, and icache may be interleaved between them only when forced.
- The waiting requester always sees wait=1; never both waits low in one cycle.
- Address and data inputs are not registered. Requesters hold address and data stable until their wait drops.

Decomposition:
- ramstate_t, word_t and the arbiter state enum (arb_state_t) go in cpu_types_pkg.
- No sub-module is required. Optionally split the grant/starve logic into arb_prio (combinational next-grant plus counter), instantiated once.

Test Plan:
- dREN=1, daddr=0x40, RAM returns ACCESS on the first DACC cycle with ramload=0xDEADBEEF -> dwait low exactly in cycle 2, dload=0xDEADBEEF, ramREN=1 with ramaddr=0x40 in that cycle, ramWEN=0.
- dWEN=1, dREN=1, daddr=0x3100, dstore=0x5 -> ramWEN=1, ramREN=0, ramstore=0x5, ramaddr=0x3100. RAM BUSY for 3 cycles then ACCESS -> dwait low only in the ACCESS cycle.
- dREN and iREN both held, RAM always ACCESS, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I.... iwait drops in cycle 10; the counter returns to 0 after the I completion.
- iREN only, iaddr=0x8, ramstate=ERROR for 2 cycles then ACCESS with ramload=0x1234 -> iwait stays high through ERROR, drops on ACCESS, iload=0x1234.
- dREN asserted, dropped while RAM BUSY -> RAM enables low the next cycle, state IDLE, no dwait-low pulse. Then nRST pulsed during IACC -> all outputs at reset values immediately, asynchronously.
